order_heap: RTL and testbench
=============================

Name: order_heap

Overview:
- Priority-queue order book for one side of the market; the responder end of the matching engine's heap command interface.
- Instantiated twice: IS_MAX=1 for the bid book (best = highest price) and IS_MAX=0 for the ask book (best = lowest price).
- Accepts one-cycle PUSH/POP/UPDATE commands, maintains a binary heap in a register array, always presents the best entry as root, and pulses done on completion.

Parameters:
- DEPTH, 64: maximum resting orders; power of two.
- ADDR_W, 6: log2(DEPTH).
- IS_MAX, 1: 1 = max-heap on price, 0 = min-heap on price.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- cmd  in  2  command from the matching engine; a one-cycle pulse, otherwise CMD_NOP
- data_in  in  32  {price[31:16], is_bot[15], qty[14:0]}
- root  out  32  heap[0]; valid whenever busy=0 and empty=0
- empty  out  1  count==0
- full  out  1  count==DEPTH
- done  out  1  one-cycle completion pulse for every accepted command
- busy  out  1  high from the cycle after cmd is accepted until done
- count  out  ADDR_W+1  number of live entries
- overflow  out  1  one-cycle pulse when a PUSH is dropped because the heap is full

Behaviour:
- Reset: count=0, state=IDLE, done=0, busy=0, overflow=0, root=0. Array contents are don't-care. Reset mid-operation aborts the operation and empties the heap.
- Commands are sampled only in IDLE. Any non-NOP cmd arriving while busy is ignored; the engine never issues one.
- Ordering uses the unsigned 16-bit price only.
  - IS_MAX=1: parent.price >= child.price.
  - IS_MAX=0: parent.price <= child.price.
  - Equal prices never swap.
- States: IDLE, SIFT_UP, SIFT_DOWN, FINISH.
- PUSH (not full):
  - Write data_in at index count, count+1, idx=count, go to SIFT_UP.
  - SIFT_UP: one cycle per level. If idx!=0 and child beats parent, swap and set idx=(idx-1)>>1. Otherwise go to FINISH.
- PUSH (full): drop the entry, pulse overflow, go to FINISH. Contents are unchanged.
- POP (not empty):
  - heap[0]<=heap[count-1], count-1, idx=0, go to SIFT_DOWN.
  - If count was 1, go straight to FINISH.
- SIFT_DOWN: one cycle per level.
  - Children are 2idx+1 and 2idx+2, each considered only if < count.
  - Select the better child; a tie selects the left child.
  - If that child beats idx, swap and set idx=child. Otherwise go to FINISH.
- POP (empty): no change, go to FINISH.
- UPDATE (not empty): heap[0].is_bot/qty <= data_in[15:0]; price is unchanged, so no sift. Go to FINISH.
- UPDATE (empty): no change, go to FINISH.
- UPDATE qty=0 is legal and stored as-is; the engine POPs instead.
- FINISH: done=1 for one cycle, busy=0, return to IDLE. root, empty and count are final and stable in the done cycle.
- Latency from the cmd cycle to the done cycle:
  - UPDATE, or POP/PUSH error case: 2 cycles.
  - PUSH: 2 + number of swaps + 1 (the terminating compare).
  - POP leaving count>=1: the same formula.
  - Worst case is about ADDR_W+3.
- root is combinational from heap[0]. It may glitch during a sift; consumers sample it only when busy=0.

Optional Feature:
- Macro: HEAP_FIFO_TIEBREAK_EN.
- Enabled:
  - Each entry carries a 16-bit arrival sequence taken from a free-running counter that increments on each accepted PUSH.
  - On equal price, the older entry (wrap-aware: (seq_a - seq_b) MSB set means a is older) beats the newer one in both sifts.
  - Result: equal-price orders pop in arrival order (price-time priority).
  - Valid while live entries span fewer than 2^15 arrivals.
  - The sequence field is not visible on root.
- Disabled: no sequence storage; pop order among equal prices is unspecified.

Decomposition:
- Shared header order_defines.v holds:
  - the PRICE/QTY/IS_BOT field macros;
  - CMD_NOP=2'd0, CMD_PUSH=2'd1, CMD_POP=2'd2, CMD_UPDATE=2'd3;
  - HEAP_ENTRY_W=32 and HEAP_SEQ_W=16.
- One sub-module, heap_cmp: combinational "a beats b" given IS_MAX, the prices and, under the macro, the sequences. It is used by both SIFT_UP and SIFT_DOWN.

Test Plan:
- IS_MAX=1, PUSH prices 100,105,102 (qty 10), each awaiting done → root.price=105, count=3; three POPs give root 102, then 100, then empty=1.
- IS_MAX=0, PUSH 50,40,60,40,45 → successive POPs expose 40,40,45,50,60. Check PUSH 40 into [50] asserts done exactly 4 cycles after cmd (one swap).
- UPDATE on root {100,0,25} with data_in qty=7 → done 2 cycles after cmd; root={100,0,7}; count unchanged.
- Fill to DEPTH=64, then PUSH again → overflow and done pulse together; count stays 64; root unchanged. POP on empty and UPDATE on empty → done only, empty stays 1.
- Assert rst during SIFT_DOWN of a 10-entry POP → count=0, empty=1, done=0 immediately. The next PUSH 77 gives root.price=77.
- With HEAP_FIFO_TIEBREAK_EN, IS_MAX=1: PUSH {100,qty1},{100,qty2},{100,qty3} → POPs return qty 1,2,3 in that order.

Source files
------------

// File: rtl/order_heap_pkg.sv
// Shared definitions for the order-book heap: command codes, entry layout and FSM states.
// Entry layout is {price[31:16], is_bot[15], qty[14:0]}.
package order_heap_pkg;

  localparam int HEAP_ENTRY_W = 32;
  localparam int HEAP_SEQ_W   = 16;

  typedef enum logic [1:0] {
    CMD_NOP    = 2'd0,
    CMD_PUSH   = 2'd1,
    CMD_POP    = 2'd2,
    CMD_UPDATE = 2'd3
  } heap_cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SIFT_UP,
    ST_SIFT_DOWN,
    ST_FINISH
  } heap_state_e;

  typedef logic [HEAP_ENTRY_W-1:0] heap_entry_t;
  typedef logic [HEAP_SEQ_W-1:0]   heap_seq_t;

  function automatic logic [15:0] entry_price(input heap_entry_t e);
    return e[31:16];
  endfunction

  function automatic logic [15:0] entry_bot_qty(input heap_entry_t e);
    return e[15:0];
  endfunction

endpackage

// File: rtl/order_heap_if.sv
// Command/status interface between the matching engine (master) and one heap book (slave).
interface order_heap_if
  import order_heap_pkg::*;
#(
  parameter int ADDR_W = 6
);

  heap_cmd_e       cmd;
  heap_entry_t     data_in;
  heap_entry_t     root;
  logic            empty;
  logic            full;
  logic            done;
  logic            busy;
  logic [ADDR_W:0] count;
  logic            overflow;

  modport master (
    output cmd, data_in,
    input  root, empty, full, done, busy, count, overflow
  );

  modport slave (
    input  cmd, data_in,
    output root, empty, full, done, busy, count, overflow
  );

endinterface

// File: rtl/order_heap_cmp.sv
// heap_cmp: combinational "a beats b" on price, with optional arrival-order tiebreak.
// Tiebreak compiled in with HEAP_FIFO_TIEBREAK_EN; otherwise equal prices never win.
module heap_cmp
  import order_heap_pkg::*;
#(
  parameter bit IS_MAX = 1'b1
) (
  input  logic [15:0] price_a,
  input  logic [15:0] price_b,
`ifdef HEAP_FIFO_TIEBREAK_EN
  input  heap_seq_t   seq_a,
  input  heap_seq_t   seq_b,
`endif
  output logic        a_beats_b
);

`ifdef HEAP_FIFO_TIEBREAK_EN
  heap_seq_t seq_diff;
  // wrap-aware age: a negative difference means a arrived first
  assign seq_diff = seq_a - seq_b;
`endif

  always_comb begin
    if (price_a != price_b) begin
      a_beats_b = IS_MAX ? (price_a > price_b) : (price_a < price_b);
    end else begin
`ifdef HEAP_FIFO_TIEBREAK_EN
      a_beats_b = seq_diff[HEAP_SEQ_W-1];
`else
      a_beats_b = 1'b0;
`endif
    end
  end

endmodule

// File: rtl/order_heap.sv
// order_heap: binary-heap priority queue for one side of the book (IS_MAX=1 bids, 0 asks).
// Optional macro HEAP_FIFO_TIEBREAK_EN adds per-entry arrival sequence for price-time priority.
//
// state        | meaning
// ST_IDLE      | waiting for a command; only state that samples cmd
// ST_SIFT_UP   | bubbling the pushed entry toward the root, one level per cycle
// ST_SIFT_DOWN | sinking the moved-up last entry after a pop, one level per cycle
// ST_FINISH    | pulse done (and overflow if the push was dropped), return to idle
module order_heap
  import order_heap_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6,
  parameter int IS_MAX = 1
) (
  input  logic        clk,
  input  logic        rst,
  order_heap_if.slave hif
);

  localparam int              IDX_W   = ADDR_W + 2;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  heap_entry_t heap_mem [DEPTH];
`ifdef HEAP_FIFO_TIEBREAK_EN
  heap_seq_t   seq_mem  [DEPTH];
  heap_seq_t   seq_next;
`endif

  heap_state_e       state;
  logic [ADDR_W:0]   count;
  logic [ADDR_W-1:0] idx;
  logic              done_r;
  logic              busy_r;
  logic              ovf_r;
  logic              ovf_pend;

  logic [ADDR_W-1:0] parent_idx;
  logic [ADDR_W-1:0] last_idx;
  logic [IDX_W-1:0]  left_full;
  logic [IDX_W-1:0]  right_full;
  logic [ADDR_W-1:0] left_idx;
  logic [ADDR_W-1:0] right_idx;
  logic [ADDR_W-1:0] best_idx;
  logic              left_ok;
  logic              right_ok;
  logic              up_beats;
  logic              lr_beats;
  logic              dn_beats;
  logic              up_swap;
  logic              dn_swap;

  assign parent_idx = (idx - ADDR_W'(1)) >> 1;
  assign last_idx   = ADDR_W'(count - (ADDR_W+1)'(1));
  assign left_full  = {1'b0, idx, 1'b1};
  assign right_full = left_full + IDX_W'(1);
  assign left_idx   = left_full[ADDR_W-1:0];
  assign right_idx  = right_full[ADDR_W-1:0];
  assign left_ok    = left_full  < {1'b0, count};
  assign right_ok   = right_full < {1'b0, count};

  // right child wins only if strictly better, so ties go left
  assign best_idx = (right_ok && lr_beats) ? right_idx : left_idx;
  assign up_swap  = (idx != '0) && up_beats;
  assign dn_swap  = left_ok && dn_beats;

  heap_cmp #(.IS_MAX(IS_MAX != 0)) u_cmp_up (
    .price_a   (entry_price(heap_mem[idx])),
    .price_b   (entry_price(heap_mem[parent_idx])),
`ifdef HEAP_FIFO_TIEBREAK_EN
    .seq_a     (seq_mem[idx]),
    .seq_b     (seq_mem[parent_idx]),
`endif
    .a_beats_b (up_beats)
  );

  heap_cmp #(.IS_MAX(IS_MAX != 0)) u_cmp_lr (
    .price_a   (entry_price(heap_mem[right_idx])),
    .price_b   (entry_price(heap_mem[left_idx])),
`ifdef HEAP_FIFO_TIEBREAK_EN
    .seq_a     (seq_mem[right_idx]),
    .seq_b     (seq_mem[left_idx]),
`endif
    .a_beats_b (lr_beats)
  );

  heap_cmp #(.IS_MAX(IS_MAX != 0)) u_cmp_dn (
    .price_a   (entry_price(heap_mem[best_idx])),
    .price_b   (entry_price(heap_mem[idx])),
`ifdef HEAP_FIFO_TIEBREAK_EN
    .seq_a     (seq_mem[best_idx]),
    .seq_b     (seq_mem[idx]),
`endif
    .a_beats_b (dn_beats)
  );

  // array contents are never reset; count alone defines which slots are live
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      count    <= '0;
      idx      <= '0;
      done_r   <= 1'b0;
      busy_r   <= 1'b0;
      ovf_r    <= 1'b0;
      ovf_pend <= 1'b0;
`ifdef HEAP_FIFO_TIEBREAK_EN
      seq_next <= '0;
`endif
    end else begin
      done_r <= 1'b0;
      ovf_r  <= 1'b0;
      case (state)
        ST_IDLE: begin
          ovf_pend <= 1'b0;
          case (hif.cmd)
            CMD_PUSH: begin
              busy_r <= 1'b1;
              if (count == DEPTH_C) begin
                ovf_pend <= 1'b1;
                state    <= ST_FINISH;
              end else begin
                heap_mem[count[ADDR_W-1:0]] <= hif.data_in;
`ifdef HEAP_FIFO_TIEBREAK_EN
                seq_mem[count[ADDR_W-1:0]]  <= seq_next;
                seq_next                    <= seq_next + HEAP_SEQ_W'(1);
`endif
                count <= count + (ADDR_W+1)'(1);
                idx   <= count[ADDR_W-1:0];
                state <= ST_SIFT_UP;
              end
            end
            CMD_POP: begin
              busy_r <= 1'b1;
              if (count == '0) begin
                state <= ST_FINISH;
              end else begin
                heap_mem[0] <= heap_mem[last_idx];
`ifdef HEAP_FIFO_TIEBREAK_EN
                seq_mem[0]  <= seq_mem[last_idx];
`endif
                count <= count - (ADDR_W+1)'(1);
                idx   <= '0;
                state <= (count == (ADDR_W+1)'(1)) ? ST_FINISH : ST_SIFT_DOWN;
              end
            end
            CMD_UPDATE: begin
              busy_r <= 1'b1;
              if (count != '0) begin
                heap_mem[0][15:0] <= entry_bot_qty(hif.data_in);
              end
              state <= ST_FINISH;
            end
            default: ;
          endcase
        end
        ST_SIFT_UP: begin
          if (up_swap) begin
            heap_mem[idx]        <= heap_mem[parent_idx];
            heap_mem[parent_idx] <= heap_mem[idx];
`ifdef HEAP_FIFO_TIEBREAK_EN
            seq_mem[idx]         <= seq_mem[parent_idx];
            seq_mem[parent_idx]  <= seq_mem[idx];
`endif
            idx <= parent_idx;
          end else begin
            state <= ST_FINISH;
          end
        end
        ST_SIFT_DOWN: begin
          if (dn_swap) begin
            heap_mem[idx]      <= heap_mem[best_idx];
            heap_mem[best_idx] <= heap_mem[idx];
`ifdef HEAP_FIFO_TIEBREAK_EN
            seq_mem[idx]       <= seq_mem[best_idx];
            seq_mem[best_idx]  <= seq_mem[idx];
`endif
            idx <= best_idx;
          end else begin
            state <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          done_r <= 1'b1;
          busy_r <= 1'b0;
          ovf_r  <= ovf_pend;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign hif.root     = (count == '0) ? '0 : heap_mem[0];
  assign hif.empty    = (count == '0);
  assign hif.full     = (count == DEPTH_C);
  assign hif.done     = done_r;
  assign hif.busy     = busy_r;
  assign hif.count    = count;
  assign hif.overflow = ovf_r;

endmodule

// File: tb/tb_order_heap.sv
// Bench for order_heap: bid (max) and ask (min) books against a queue-based reference model.
module tb_order_heap;
  import order_heap_pkg::*;

  localparam int ADDR_W = 6;
  localparam int DEPTH  = 64;
`ifdef HEAP_FIFO_TIEBREAK_EN
  localparam heap_entry_t CMP_MASK = 32'hFFFF_FFFF;
`else
  localparam heap_entry_t CMP_MASK = 32'hFFFF_0000;
`endif

  logic clk = 1'b0;
  logic rst_bid;
  logic rst_ask;

  always #5 clk = ~clk;

  order_heap_if #(.ADDR_W(ADDR_W)) bid_if ();
  order_heap_if #(.ADDR_W(ADDR_W)) ask_if ();

  order_heap #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .IS_MAX(1)) u_bid (
    .clk (clk),
    .rst (rst_bid),
    .hif (bid_if)
  );

  order_heap #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .IS_MAX(0)) u_ask (
    .clk (clk),
    .rst (rst_ask),
    .hif (ask_if)
  );

  // reference model: unordered entries with arrival numbers per book
  heap_entry_t bid_q[$];
  heap_entry_t ask_q[$];
  int          bid_s[$];
  int          ask_s[$];
  int          arrival = 0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic heap_entry_t mk(input int p, input bit bot, input int q);
    return {p[15:0], bot, q[14:0]};
  endfunction

  function automatic int best_of(input heap_entry_t q[$], input int s[$], input bit min_side);
    int b;
    logic [15:0] pi;
    logic [15:0] pb;
    b = 0;
    for (int i = 1; i < q.size(); i++) begin
      pi = q[i][31:16];
      pb = q[b][31:16];
      if ((min_side ? (pi < pb) : (pi > pb)) || (pi == pb && s[i] < s[b])) b = i;
    end
    return b;
  endfunction

  task automatic drive(input bit ask, input heap_cmd_e c, input heap_entry_t d);
    if (ask) begin
      ask_if.cmd = c;
      ask_if.data_in = d;
    end else begin
      bid_if.cmd = c;
      bid_if.data_in = d;
    end
  endtask

  // issue one command, update the model, wait for done and compare; returns at a
  // negedge inside the done cycle with the cycle count from cmd to done
  task automatic run_cmd(input bit ask, input heap_cmd_e c, input heap_entry_t d, output int lat);
    heap_entry_t q[$];
    int          s[$];
    int          b;
    bit          exp_ovf;
    logic        g_done;
    heap_entry_t g_root;
    if (ask) begin q = ask_q; s = ask_s; end
    else     begin q = bid_q; s = bid_s; end
    exp_ovf = 1'b0;
    case (c)
      CMD_PUSH: begin
        if (q.size() == DEPTH) exp_ovf = 1'b1;
        else begin
          q.push_back(d);
          s.push_back(arrival);
          arrival++;
        end
      end
      CMD_POP: begin
        if (q.size() != 0) begin
          b = best_of(q, s, ask);
          q.delete(b);
          s.delete(b);
        end
      end
      CMD_UPDATE: begin
        if (q.size() != 0) begin
          b = best_of(q, s, ask);
          q[b][15:0] = d[15:0];
        end
      end
      default: ;
    endcase

    @(negedge clk);
    drive(ask, c, d);
    @(negedge clk);
    drive(ask, CMD_NOP, '0);
    lat = 1;
    g_done = ask ? ask_if.done : bid_if.done;
    while (!g_done && lat < 40) begin
      @(negedge clk);
      lat++;
      g_done = ask ? ask_if.done : bid_if.done;
    end
    check("done_seen", g_done, 1);
    check("overflow", ask ? ask_if.overflow : bid_if.overflow, exp_ovf);
    check("busy_at_done", ask ? ask_if.busy : bid_if.busy, 0);
    check("count", ask ? ask_if.count : bid_if.count, q.size());
    check("empty", ask ? ask_if.empty : bid_if.empty, q.size() == 0);
    if (q.size() != 0) begin
      b = best_of(q, s, ask);
      g_root = ask ? ask_if.root : bid_if.root;
      check("root", g_root & CMP_MASK, q[b] & CMP_MASK);
    end
    if (ask) begin ask_q = q; ask_s = s; end
    else     begin bid_q = q; bid_s = s; end
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int max_p;
    int p;
    int ask_exp [5];
    rst_bid = 1'b1;
    rst_ask = 1'b1;
    drive(0, CMD_NOP, '0);
    drive(1, CMD_NOP, '0);
    repeat (3) @(negedge clk);

    check("rst_count", bid_if.count, 0);
    check("rst_empty", bid_if.empty, 1);
    check("rst_done", bid_if.done, 0);
    check("rst_busy", bid_if.busy, 0);
    check("rst_overflow", bid_if.overflow, 0);
    check("rst_root", bid_if.root, 0);
    rst_bid = 1'b0;
    rst_ask = 1'b0;

    // bid book basic ordering
    run_cmd(0, CMD_PUSH, mk(100, 0, 10), lat);
    run_cmd(0, CMD_PUSH, mk(105, 0, 10), lat);
    run_cmd(0, CMD_PUSH, mk(102, 0, 10), lat);
    check("bid_root_105", bid_if.root[31:16], 105);
    check("bid_count_3", bid_if.count, 3);
    run_cmd(0, CMD_POP, '0, lat);
    check("bid_root_102", bid_if.root[31:16], 102);
    run_cmd(0, CMD_POP, '0, lat);
    check("bid_root_100", bid_if.root[31:16], 100);
    run_cmd(0, CMD_POP, '0, lat);
    check("bid_empty_after_pops", bid_if.empty, 1);

    // update keeps price, replaces is_bot/qty
    run_cmd(0, CMD_PUSH, mk(100, 0, 25), lat);
    run_cmd(0, CMD_UPDATE, mk(999, 0, 7), lat);
    check("update_latency", lat, 2);
    check("update_root", bid_if.root, mk(100, 0, 7));
    check("update_count", bid_if.count, 1);
    run_cmd(0, CMD_POP, '0, lat);

    // fill, overflow, drain, empty-side errors
    max_p = 0;
    for (int i = 0; i < DEPTH; i++) begin
      p = $urandom_range(0, 500);
      if (p > max_p) max_p = p;
      run_cmd(0, CMD_PUSH, mk(p, $urandom_range(0, 1), $urandom_range(1, 32767)), lat);
    end
    check("full_flag", bid_if.full, 1);
    run_cmd(0, CMD_PUSH, mk(9999, 0, 1), lat);
    check("ovf_latency", lat, 2);
    check("ovf_pulse", bid_if.overflow, 1);
    check("ovf_count", bid_if.count, 64);
    check("ovf_root_price", bid_if.root[31:16], max_p);
    for (int i = 0; i < DEPTH; i++) run_cmd(0, CMD_POP, '0, lat);
    run_cmd(0, CMD_POP, '0, lat);
    check("pop_empty_latency", lat, 2);
    check("pop_empty_empty", bid_if.empty, 1);
    run_cmd(0, CMD_UPDATE, mk(1, 0, 5), lat);
    check("upd_empty_latency", lat, 2);
    check("upd_empty_empty", bid_if.empty, 1);

    // ask book ordering and one-swap latency
    run_cmd(1, CMD_PUSH, mk(50, 0, 1), lat);
    check("push_noswap_latency", lat, 3);
    run_cmd(1, CMD_PUSH, mk(40, 0, 2), lat);
    check("push_oneswap_latency", lat, 4);
    run_cmd(1, CMD_PUSH, mk(60, 0, 3), lat);
    run_cmd(1, CMD_PUSH, mk(40, 0, 4), lat);
    run_cmd(1, CMD_PUSH, mk(45, 0, 5), lat);
    ask_exp = '{40, 40, 45, 50, 60};
    for (int k = 0; k < 5; k++) begin
      check("ask_pop_order", ask_if.root[31:16], ask_exp[k]);
      run_cmd(1, CMD_POP, '0, lat);
    end
    check("ask_empty", ask_if.empty, 1);

    // randomized traffic with clustered prices to force ties
    for (int bk = 0; bk < 2; bk++) begin
      for (int n = 0; n < 300; n++) begin
        int r;
        heap_cmd_e c;
        r = $urandom_range(0, 99);
        c = (r < 50) ? CMD_PUSH : (r < 85) ? CMD_POP : CMD_UPDATE;
        run_cmd(bk[0], c, mk(1000 + $urandom_range(0, 12), $urandom_range(0, 1),
                             $urandom_range(0, 32767)), lat);
      end
    end

    // reset during a sift-down aborts and empties
    rst_bid = 1'b1;
    @(negedge clk);
    rst_bid = 1'b0;
    bid_q.delete();
    bid_s.delete();
    for (int i = 0; i < 10; i++) run_cmd(0, CMD_PUSH, mk(10 * (i + 1), 0, i + 1), lat);
    @(negedge clk);
    drive(0, CMD_POP, '0);
    @(negedge clk);
    drive(0, CMD_NOP, '0);
    check("mid_pop_busy", bid_if.busy, 1);
    rst_bid = 1'b1;
    #1;
    check("abort_count", bid_if.count, 0);
    check("abort_empty", bid_if.empty, 1);
    check("abort_done", bid_if.done, 0);
    bid_q.delete();
    bid_s.delete();
    @(negedge clk);
    rst_bid = 1'b0;
    run_cmd(0, CMD_PUSH, mk(77, 0, 3), lat);
    check("post_reset_root", bid_if.root[31:16], 77);

`ifdef HEAP_FIFO_TIEBREAK_EN
    run_cmd(0, CMD_PUSH, mk(100, 0, 1), lat);
    run_cmd(0, CMD_PUSH, mk(100, 0, 2), lat);
    run_cmd(0, CMD_PUSH, mk(100, 0, 3), lat);
    for (int k = 1; k <= 3; k++) begin
      check("fifo_tie_qty", bid_if.root[14:0], k);
      run_cmd(0, CMD_POP, '0, lat);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
